// File: rtl/gdp_bitscan_param.sv
// Parametrised bit-scan GDP: counts ones/zeros or leading/trailing zeros of a
// WIDTH-bit operand, STEP bits per clock, with a start/restart/done handshake.
module gdp_bitscan_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             restart,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] n_in,
  output logic [CNT_W-1:0] runSum,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NCHUNK = (STEP == 0) ? 1 : WIDTH / STEP;
  localparam int unsigned CW     = $clog2(NCHUNK + 1);

  localparam logic [1:0] ModeOnes  = 2'b00;
  localparam logic [1:0] ModeZeros = 2'b01;
  localparam logic [1:0] ModeLead  = 2'b10;

  if ((WIDTH < 2) || (STEP == 0) || ((WIDTH % STEP) != 0)) begin : g_param_err
    $error("gdp_bitscan_param: WIDTH must be >= 2 and a multiple of STEP");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] sum_q, sum_d;

  logic [STEP-1:0]  chunk;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] ones, lead, trail, incr;
  logic             last, finish, found;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: operand, captured mode, chunk counter, accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opnd_q <= '0;
      mode_q <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
    end else begin
      opnd_q <= opnd_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
    end
  end

  // Examine the current chunk: popcount and position of the first 1 in scan direction.
  always_comb begin
    chunk   = (mode_q == ModeLead) ? opnd_q[WIDTH-1 -: STEP] : opnd_q[STEP-1:0];
    shifted = (mode_q == ModeLead) ? (opnd_q << STEP) : (opnd_q >> STEP);
    last    = (cnt_q == CW'(NCHUNK - 1));
    ones    = '0;
    lead    = CNT_W'(STEP);
    trail   = CNT_W'(STEP);
    found   = 1'b0;
    for (int i = 0; i < int'(STEP); i++) begin
      ones = ones + CNT_W'(chunk[i]);
      // Ascending loop: the highest set bit is the last to write lead.
      if (chunk[i]) lead = CNT_W'(int'(STEP) - 1 - i);
      if (chunk[i] && !found) begin
        trail = CNT_W'(i);
        found = 1'b1;
      end
    end
    unique case (mode_q)
      ModeOnes: begin
        incr   = ones;
        finish = (shifted == '0) || last;
      end
      ModeZeros: begin
        incr   = CNT_W'(STEP) - ones;
        finish = last;
      end
      default: begin
        // Zero chunk contributes STEP; a 1 ends the scan early.
        incr   = (mode_q == ModeLead) ? lead : trail;
        finish = found || last;
      end
    endcase
  end

  // FSM next-state: restart dominates, start only honoured in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (!restart && start) state_d = StScan;
      StScan: begin
        if (restart) state_d = StIdle;
        else if (finish) state_d = StDone;
      end
      StDone: if (restart) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: capture on start, accumulate per chunk, clear on restart.
  always_comb begin
    opnd_d = opnd_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    unique case (state_q)
      StIdle: begin
        if (restart) begin
          sum_d = '0;
        end else if (start) begin
          opnd_d = n_in;
          mode_d = mode;
          cnt_d  = '0;
          sum_d  = '0;
        end
      end
      StScan: begin
        if (restart) begin
          cnt_d = '0;
          sum_d = '0;
        end else begin
          opnd_d = shifted;
          cnt_d  = cnt_q + 1'b1;
          sum_d  = sum_q + incr;
        end
      end
      StDone: if (restart) sum_d = '0;
      default: sum_d = '0;
    endcase
  end

  // Outputs decoded from state; accumulator exposed directly.
  always_comb begin
    runSum = sum_q;
    done   = (state_q == StDone);
    busy   = (state_q == StScan);
  end

endmodule

// File: tb/tb_gdp_bitscan_param.sv
module tb_gdp_bitscan_param;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        start_a = 1'b0, restart_a = 1'b0;
  logic [1:0]  mode_a = 2'b00;
  logic [7:0]  n_a = 8'h00;
  logic [3:0]  sum_a;
  logic        done_a, busy_a;

  logic        start_b = 1'b0, restart_b = 1'b0;
  logic [1:0]  mode_b = 2'b00;
  logic [15:0] n_b = 16'h0000;
  logic [4:0]  sum_b;
  logic        done_b, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gdp_bitscan_param #(.WIDTH(8), .STEP(1)) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_a),
    .restart (restart_a),
    .mode    (mode_a),
    .n_in    (n_a),
    .runSum  (sum_a),
    .done    (done_a),
    .busy    (busy_a)
  );

  gdp_bitscan_param #(.WIDTH(16), .STEP(4)) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_b),
    .restart (restart_b),
    .mode    (mode_b),
    .n_in    (n_b),
    .runSum  (sum_b),
    .done    (done_b),
    .busy    (busy_b)
  );

  // Reference: result straight from the definition of each mode.
  function automatic int model_sum(int w, logic [1:0] m, logic [15:0] v);
    int pop = 0, lz = w, tz = w;
    for (int i = 0; i < w; i++) if (v[i]) pop++;
    for (int i = 0; i < w; i++) if (v[i]) lz = w - 1 - i;
    for (int i = w - 1; i >= 0; i--) if (v[i]) tz = i;
    case (m)
      2'b00:   return pop;
      2'b01:   return w - pop;
      2'b10:   return lz;
      default: return tz;
    endcase
  endfunction

  // Reference: number of chunks consumed before done.
  function automatic int model_k(int w, int s, logic [1:0] m, logic [15:0] v);
    int n = w / s, hi = -1, lz, tz;
    for (int i = 0; i < w; i++) if (v[i]) hi = i;
    lz = model_sum(w, 2'b10, v);
    tz = model_sum(w, 2'b11, v);
    case (m)
      2'b00:   return (hi < 0) ? 1 : hi / s + 1;
      2'b01:   return n;
      2'b10:   return (lz == w) ? n : lz / s + 1;
      default: return (tz == w) ? n : tz / s + 1;
    endcase
  endfunction

  // Launch one operation and wait (bounded) for done; inputs scrambled during scan.
  task automatic run_op(input bit wide, input logic [1:0] m, input logic [15:0] v,
                        output int sum, output int edges, output bit ok);
    @(negedge clock);
    if (wide) begin mode_b = m; n_b = v; start_b = 1'b1; end
    else begin mode_a = m; n_a = v[7:0]; start_a = 1'b1; end
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    ok = 1'b0; edges = 0; sum = -1;
    while (!ok && edges < 40) begin
      n_a = 8'($urandom); n_b = 16'($urandom);
      mode_a = 2'($urandom); mode_b = 2'($urandom);
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (wide ? done_b : done_a) begin
        ok = 1'b1;
        sum = wide ? int'(sum_b) : int'(sum_a);
      end
    end
  endtask

  task automatic do_restart(input bit wide);
    @(negedge clock);
    if (wide) restart_b = 1'b1; else restart_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    restart_a = 1'b0;
    restart_b = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({sum_a, done_a, busy_a, sum_b, done_b, busy_b} !== '0) begin
      errors++;
      $display("FAIL reset_state got a=%0d/%b/%b b=%0d/%b/%b want all 0",
               sum_a, done_a, busy_a, sum_b, done_b, busy_b);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_scan();
    int s, k;
    bit ok;
    @(negedge clock);
    mode_a = 2'b00; n_a = 8'hFF; start_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (busy_a !== 1'b1 || sum_a !== 4'd3) begin
      errors++;
      $display("FAIL mid_scan_pre got busy=%b sum=%0d want busy=1 sum=3", busy_a, sum_a);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (sum_a !== 4'd0 || done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got sum=%0d done=%b busy=%b want 0/0/0",
               sum_a, done_a, busy_a);
    end
    @(negedge clock);
    reset_n = 1'b1;
    run_op(1'b0, 2'b00, 16'h000F, s, k, ok);
    checks++;
    if (!ok || s != 4 || k != 4) begin
      errors++;
      $display("FAIL after_reset got ok=%b sum=%0d edges=%0d want sum=4 edges=4", ok, s, k);
    end
    do_restart(1'b0);
  endtask

  typedef struct {
    bit          wide;
    logic [1:0]  m;
    logic [15:0] v;
    int          s;
    int          k;
  } vec_t;

  vec_t dir_tbl [17] = '{
    '{1'b0, 2'b00, 16'h0000, 0, 1}, '{1'b0, 2'b00, 16'h0001, 1, 1},
    '{1'b0, 2'b00, 16'h00FF, 8, 8}, '{1'b0, 2'b00, 16'h0080, 1, 8},
    '{1'b0, 2'b00, 16'h00E3, 5, 8}, '{1'b0, 2'b00, 16'h000F, 4, 4},
    '{1'b0, 2'b01, 16'h00E3, 3, 8}, '{1'b0, 2'b01, 16'h0000, 8, 8},
    '{1'b0, 2'b10, 16'h0010, 3, 4}, '{1'b0, 2'b10, 16'h0000, 8, 8},
    '{1'b0, 2'b11, 16'h00A0, 5, 6}, '{1'b0, 2'b11, 16'h0001, 0, 1},
    '{1'b1, 2'b00, 16'hFFFF, 16, 4}, '{1'b1, 2'b00, 16'h000F, 4, 1},
    '{1'b1, 2'b10, 16'h0100, 7, 2}, '{1'b1, 2'b11, 16'h8000, 15, 4},
    '{1'b1, 2'b10, 16'h0000, 16, 4}
  };

  task automatic test_directed();
    int s, k;
    bit ok;
    foreach (dir_tbl[i]) begin
      run_op(dir_tbl[i].wide, dir_tbl[i].m, dir_tbl[i].v, s, k, ok);
      checks++;
      if (!ok || s != dir_tbl[i].s || k != dir_tbl[i].k) begin
        errors++;
        $display("FAIL directed[%0d] m=%b v=%h got ok=%b sum=%0d edges=%0d want %0d/%0d",
                 i, dir_tbl[i].m, dir_tbl[i].v, ok, s, k, dir_tbl[i].s, dir_tbl[i].k);
      end
      do_restart(dir_tbl[i].wide);
    end
  endtask

  task automatic test_exhaustive_ones();
    int s, k;
    bit ok;
    for (int v = 0; v < 256; v++) begin
      run_op(1'b0, 2'b00, 16'(v), s, k, ok);
      checks++;
      if (!ok || s != model_sum(8, 2'b00, 16'(v)) || k != model_k(8, 1, 2'b00, 16'(v))
          || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL ones v=%h got ok=%b sum=%0d edges=%0d busy=%b want %0d/%0d",
                 v, ok, s, k, busy_a, model_sum(8, 2'b00, 16'(v)), model_k(8, 1, 2'b00, 16'(v)));
      end
      do_restart(1'b0);
      checks++;
      if (done_a !== 1'b0 || sum_a !== 4'd0) begin
        errors++;
        $display("FAIL ones_restart v=%h got done=%b sum=%0d want 0/0", v, done_a, sum_a);
      end
    end
  endtask

  task automatic test_random();
    int s, k, w, st;
    bit ok, wide;
    logic [1:0] m;
    logic [15:0] v;
    for (int n = 0; n < 200; n++) begin
      wide = 1'($urandom);
      m = 2'($urandom);
      v = 16'($urandom);
      // Bias toward sparse operands so early exits are exercised.
      if ($urandom_range(0, 2) == 0) v = v & 16'($urandom) & 16'($urandom);
      if (!wide) v[15:8] = 8'h00;
      w = wide ? 16 : 8;
      st = wide ? 4 : 1;
      run_op(wide, m, v, s, k, ok);
      checks++;
      if (!ok || s != model_sum(w, m, v) || k != model_k(w, st, m, v)) begin
        errors++;
        $display("FAIL random w=%0d m=%b v=%h got ok=%b sum=%0d edges=%0d want %0d/%0d",
                 w, m, v, ok, s, k, model_sum(w, m, v), model_k(w, st, m, v));
      end
      do_restart(wide);
    end
  endtask

  task automatic test_restart_in_scan();
    bit rose = 1'b0;
    @(negedge clock);
    mode_a = 2'b01; n_a = 8'($urandom); start_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
      if (done_a) rose = 1'b1;
    end
    restart_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    restart_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || sum_a !== 4'd0) begin
      errors++;
      $display("FAIL abort got busy=%b done=%b sum=%0d want 0/0/0", busy_a, done_a, sum_a);
    end
    repeat (10) begin
      @(posedge clock);
      @(negedge clock);
      if (done_a || busy_a) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL abort_quiet got done/busy activity=1 want 0");
    end
  endtask

  task automatic test_start_restart_in_done();
    int s, k;
    bit ok;
    run_op(1'b0, 2'b01, 16'($urandom_range(0, 255)), s, k, ok);
    checks++;
    if (!ok || done_a !== 1'b1) begin
      errors++;
      $display("FAIL sr_setup got ok=%b done=%b want 1/1", ok, done_a);
    end
    start_a = 1'b1;
    restart_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    restart_a = 1'b0;
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || sum_a !== 4'd0) begin
      errors++;
      $display("FAIL sr_in_done got done=%b busy=%b sum=%0d want 0/0/0", done_a, busy_a, sum_a);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL sr_not_taken got busy=%b want 0", busy_a);
    end
  endtask

  task automatic test_back_to_back();
    int s, k, edges;
    bit ok;
    logic [7:0] v2;
    run_op(1'b0, 2'b00, 16'h00C3, s, k, ok);
    checks++;
    if (!ok || s != 4) begin
      errors++;
      $display("FAIL b2b_first got ok=%b sum=%0d want 4", ok, s);
    end
    v2 = 8'($urandom);
    mode_a = 2'b00; n_a = v2; start_a = 1'b1; restart_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    restart_a = 1'b0;
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got done=%b busy=%b want 0/0", done_a, busy_a);
    end
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b want 1", busy_a);
    end
    edges = 0;
    ok = 1'b0;
    while (!ok && edges < 40) begin
      n_a = 8'($urandom);
      @(posedge clock);
      edges++;
      @(negedge clock);
      ok = done_a;
    end
    checks++;
    if (!ok || int'(sum_a) != model_sum(8, 2'b00, 16'(v2))
        || edges != model_k(8, 1, 2'b00, 16'(v2))) begin
      errors++;
      $display("FAIL b2b_second v=%h got ok=%b sum=%0d edges=%0d want %0d/%0d", v2, ok,
               sum_a, edges, model_sum(8, 2'b00, 16'(v2)), model_k(8, 1, 2'b00, 16'(v2)));
    end
    do_restart(1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_scan();
    test_directed();
    test_exhaustive_ones();
    test_random();
    test_restart_in_scan();
    test_start_restart_in_done();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gdp_bitscan_param.md
Name: gdp_bitscan_param

Overview:
- Parametrised successor to the 8-bit ones-counter general data path (GDP): control FSM and datapath in one block.
- Scans a WIDTH-bit operand STEP bits per clock.
- Four modes: count ones, count zeros, leading zeros, trailing zeros. Count-ones mode terminates early.
- Keeps the start/restart/done handshake and adds asynchronous reset and a busy flag, so existing GDP benches port directly.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥2.
- STEP, 1, bits examined per SCAN cycle; must divide WIDTH exactly (elaboration error otherwise).
- CNT_W (localparam), $clog2(WIDTH+1), result width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- restart  in  1  synchronous abort/acknowledge; honoured in every state
- mode  in  2  00 ones, 01 zeros, 10 leading zeros, 11 trailing zeros; captured with start
- n_in  in  WIDTH  operand; captured with start
- runSum  out  CNT_W  running accumulator; final result when done=1
- done  out  1  result valid, held until restart
- busy  out  1  high while in SCAN

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, runSum=0, done=0, busy=0, operand and chunk-counter registers=0. Reset wins over every input, including mid-SCAN.
- FSM states: IDLE, SCAN, DONE. Encoding is free; only the outputs are checked.
- IDLE:
  - On the edge with start=1 and restart=0, capture n_in and mode, clear runSum and chunk counter, go to SCAN.
  - n_in and mode may change freely after that edge.
- SCAN, one chunk of STEP bits per edge; busy=1, done=0:
  - Modes 00, 01, 11 take the chunk from the LSB end; the operand shifts right by STEP.
  - Mode 10 takes the chunk from the MSB end; the operand shifts left by STEP.
  - 00: runSum += popcount(chunk). Go to DONE when the shifted operand is 0 or all WIDTH/STEP chunks are consumed.
  - 01: runSum += STEP − popcount(chunk). No early exit; always exactly WIDTH/STEP edges.
  - 10/11: if the chunk is all zero, runSum += STEP. Otherwise runSum += the number of zeros before the first 1 in scan direction, and go to DONE. Also go to DONE after the last chunk, so operand 0 gives runSum=WIDTH.
  - runSum and the state update on the same edge. done rises after the edge that processes the final chunk.
  - runSum never exceeds WIDTH; no overflow is possible at CNT_W bits.
- Latency, counted from the start-sampling edge E0:
  - Done after edge E(k), where k = chunks processed.
  - Minimum k=1: mode 00 with operand bits above STEP all zero, or mode 10/11 with a 1 in the first chunk.
  - Maximum k=WIDTH/STEP.
- DONE:
  - done=1, busy=0, runSum held stable. start is ignored.
  - restart=1 → IDLE at the next edge; done=0 and runSum=0 after that edge.
- restart during SCAN aborts: IDLE at the next edge, runSum=0, done stays 0, no partial result exposed.
- restart=1 in IDLE: remain in IDLE, start is blocked that cycle.
- start and restart both 1 in any state: restart wins.
- The next operation needs start seen in IDLE at least one edge after the restart edge.
- start held high through DONE→IDLE is re-accepted on the first IDLE edge with restart=0, which gives back-to-back operation.

Test Plan:
- Reset mid-scan: WIDTH=8, STEP=1, mode 00, n_in=8'hFF. Assert reset_n=0 after the 3rd SCAN edge → runSum=0, done=0, busy=0 immediately, without waiting for a clock edge. After release, start with n_in=8'h0F → runSum=4, done after 4 SCAN edges.
- Exhaustive ones count: n_in 0..255, mode 00, WIDTH=8/STEP=1.
  - runSum equals the bench's own count of set bits for every value.
  - 8'h00 and 8'h01 → done after 1 SCAN edge; 8'hFF and 8'h80 → after 8; 8'hE3 → 5, after 8.
  - Also check n_in driven to a new value during SCAN does not alter the result.
- Zero count: mode 01, n_in=8'hE3 → runSum=3, done after exactly 8 SCAN edges; n_in=8'h00 → 8.
- Leading/trailing zeros:
  - mode 10, n_in=8'h10 → 3, done after 4 edges.
  - mode 10, n_in=8'h00 → 8, done after 8 edges.
  - mode 11, n_in=8'hA0 → 5, done after 6 edges.
  - mode 11, n_in=8'h01 → 0, done after 1 edge.
- Wide/multi-bit build, WIDTH=16, STEP=4:
  - mode 00, 16'hFFFF → 16 after 4 edges.
  - mode 00, 16'h000F → 4 after 1 edge.
  - mode 10, 16'h0100 → 7 after 2 edges.
  - mode 11, 16'h8000 → 15 after 4 edges.
- Handshake edges:
  - restart during SCAN → IDLE, done never rises, runSum=0.
  - start=restart=1 in DONE → IDLE, start not taken that edge.
  - start held through DONE→IDLE with a new n_in → new result correct, done low for at least 1 cycle between results.
